regfile_param: RTL and testbench

REGFILE_PARAM -- requirements
Module: regfile_param

---
 rtl/regfile_pkg.sv | 19 +
 rtl/regfile_init_ctrl.sv | 65 ++++++
 rtl/regfile_param.sv | 83 ++++++++
 tb/tb_regfile_param.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and defaults for the parameterised register file.
package regfile_pkg;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_e;

  localparam int DEF_DATA_W   = 64;
  localparam int DEF_ADDR_W   = 5;
  localparam int DEF_NUM_RD   = 2;
  localparam int DEF_ZERO_IDX = (1 << DEF_ADDR_W) - 1;

  // The zero register is always the last entry of the array.
  function automatic int zero_idx(input int addr_w);
    return (1 << addr_w) - 1;
  endfunction

endpackage

// File: rtl/regfile_init_ctrl.sv
// Clear-sweep controller: walks every entry after reset or a clear request,
// reporting busy while the array contents are not yet valid.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_INIT  | sweep in progress, entry cnt_q is zeroed on each rising edge
// ST_READY | array valid, normal reads and writes
module regfile_init_ctrl
  import regfile_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_req,
  output logic              clr_en,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] LAST_IDX = {ADDR_W{1'b1}};

  state_e            state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic              busy_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      case (state_q)
        ST_INIT: begin
          if (clr_req) begin
            cnt_q <= '0;
          end else if (cnt_q == LAST_IDX) begin
            state_q <= ST_READY;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_READY: begin
          if (clr_req) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_INIT;
          cnt_q   <= '0;
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

  assign clr_en   = busy_q;
  assign clr_addr = cnt_q;
  assign busy     = busy_q;

endmodule

// File: rtl/regfile_param.sv
// Multi-read, dual-write register file with optional hardwired zero entry,
// same-cycle write-to-read bypass and a sequenced clear sweep.
module regfile_param
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = DEF_NUM_RD,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     wa_en,
  input  logic [ADDR_W-1:0]        wa_addr,
  input  logic [DATA_W-1:0]        wa_data,
  input  logic                     wb_en,
  input  logic [ADDR_W-1:0]        wb_addr,
  input  logic [DATA_W-1:0]        wb_data,
  input  logic                     clr_req,
  output logic                     busy
);

  localparam int                DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(zero_idx(ADDR_W));
  localparam logic              ZERO_ON  = (ZERO_REG != 0);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              clr_en;
  logic [ADDR_W-1:0] clr_addr;
  logic              wa_ok;
  logic              wb_ok;

  regfile_init_ctrl #(
    .ADDR_W(ADDR_W)
  ) u_ctrl (
    .clk     (clk),
    .rst     (rst),
    .clr_req (clr_req),
    .clr_en  (clr_en),
    .clr_addr(clr_addr),
    .busy    (busy)
  );

  assign wa_ok = wa_en && !(ZERO_ON && (wa_addr == ZERO_IDX));
  assign wb_ok = wb_en && !(ZERO_ON && (wb_addr == ZERO_IDX));

  // No reset on the array so it can map onto RAM; the sweep zeroes it instead.
  // Port B is written last so it wins an address collision.
  always_ff @(posedge clk) begin
    if (clr_en) begin
      mem_q[clr_addr] <= '0;
    end else begin
      if (wa_ok) mem_q[wa_addr] <= wa_data;
      if (wb_ok) mem_q[wb_addr] <= wb_data;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] word;

    assign addr = rd_addr[k*ADDR_W +: ADDR_W];

    always_comb begin
      word = mem_q[addr];
      if (busy) begin
        word = '0;
      end else if (ZERO_ON && (addr == ZERO_IDX)) begin
        word = '0;
      end else if (wb_en && (wb_addr == addr)) begin
        word = wb_data;
      end else if (wa_en && (wa_addr == addr)) begin
        word = wa_data;
      end
    end

    assign rd_data[k*DATA_W +: DATA_W] = word;
  end

endmodule

// File: tb/tb_regfile_param.sv
// Directed self-checking bench for regfile_param with default parameters.
module tb_regfile_param;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 5;
  localparam int NUM_RD = 2;
  localparam int DEPTH  = 32;

  logic                     clk;
  logic                     rst;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic                     wa_en;
  logic [ADDR_W-1:0]        wa_addr;
  logic [DATA_W-1:0]        wa_data;
  logic                     wb_en;
  logic [ADDR_W-1:0]        wb_addr;
  logic [DATA_W-1:0]        wb_data;
  logic                     clr_req;
  logic                     busy;

  int n_tests;
  int n_fail;

  regfile_param #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .NUM_RD  (NUM_RD),
    .ZERO_REG(1)
  ) u_dut (
    .clk    (clk),
    .rst    (rst),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .wa_en  (wa_en),
    .wa_addr(wa_addr),
    .wa_data(wa_data),
    .wb_en  (wb_en),
    .wb_addr(wb_addr),
    .wb_data(wb_data),
    .clr_req(clr_req),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input int port, input logic [ADDR_W-1:0] a);
    rd_addr[port*ADDR_W +: ADDR_W] = a;
  endtask

  function automatic logic [63:0] rd(input int port);
    return rd_data[port*DATA_W +: DATA_W];
  endfunction

  // Counts cycles until busy drops, bounded so a stuck busy still terminates.
  task automatic count_busy(input string tag, input int exp_cycles);
    int n;
    n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    check(tag, 64'(n), 64'(exp_cycles));
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    rd_addr = '0;
    wa_en   = 1'b0;
    wa_addr = '0;
    wa_data = '0;
    wb_en   = 1'b0;
    wb_addr = '0;
    wb_data = '0;
    clr_req = 1'b0;

    #2;
    check("reset_busy_async", 64'(busy), 64'd1);
    check("reset_rd0", rd(0), 64'd0);
    tick();
    tick();
    rst = 1'b0;
    check("reset_cnt", 64'(u_dut.u_ctrl.cnt_q), 64'd0);
    count_busy("init_busy_cycles", DEPTH);

    for (int a = 0; a < DEPTH; a++) begin
      set_rd(0, ADDR_W'(a));
      set_rd(1, ADDR_W'(DEPTH - 1 - a));
      #1;
      check($sformatf("post_init_rd0_%0d", a), rd(0), 64'd0);
      check($sformatf("post_init_rd1_%0d", DEPTH - 1 - a), rd(1), 64'd0);
    end

    // Write A with same-cycle bypass, then from the array.
    wa_en = 1'b1; wa_addr = 5'd3; wa_data = 64'hDEAD_BEEF;
    set_rd(0, 5'd3);
    set_rd(1, 5'd4);
    #1;
    check("bypass_a_rd0", rd(0), 64'hDEAD_BEEF);
    check("bypass_a_other_rd1", rd(1), 64'd0);
    tick();
    wa_en = 1'b0;
    #1;
    check("stored_a_rd0", rd(0), 64'hDEAD_BEEF);
    set_rd(1, 5'd3);
    #1;
    check("stored_a_rd1_same_addr", rd(1), 64'hDEAD_BEEF);

    // Both ports to the same address: B wins.
    wa_en = 1'b1; wa_addr = 5'd7; wa_data = 64'h11;
    wb_en = 1'b1; wb_addr = 5'd7; wb_data = 64'h22;
    set_rd(0, 5'd7);
    #1;
    check("collide_bypass", rd(0), 64'h22);
    tick();
    wa_en = 1'b0; wb_en = 1'b0;
    #1;
    check("collide_stored", rd(0), 64'h22);

    // Distinct addresses on both ports in one cycle.
    wa_en = 1'b1; wa_addr = 5'd9;  wa_data = 64'h0123_4567_89AB_CDEF;
    wb_en = 1'b1; wb_addr = 5'd10; wb_data = 64'hFEDC_BA98_7654_3210;
    set_rd(0, 5'd9);
    set_rd(1, 5'd10);
    #1;
    check("dual_bypass_rd0", rd(0), 64'h0123_4567_89AB_CDEF);
    check("dual_bypass_rd1", rd(1), 64'hFEDC_BA98_7654_3210);
    tick();
    wa_en = 1'b0; wb_en = 1'b0;
    #1;
    check("dual_stored_rd0", rd(0), 64'h0123_4567_89AB_CDEF);
    check("dual_stored_rd1", rd(1), 64'hFEDC_BA98_7654_3210);

    // Zero register ignores writes and bypass.
    wa_en = 1'b1; wa_addr = 5'd31; wa_data = 64'hFFFF;
    wb_en = 1'b1; wb_addr = 5'd31; wb_data = 64'h5555;
    set_rd(1, 5'd31);
    #1;
    check("xzr_bypass", rd(1), 64'd0);
    tick();
    wa_en = 1'b0; wb_en = 1'b0;
    #1;
    check("xzr_stored", rd(1), 64'd0);

    // Clear request wipes the array and blocks writes during the sweep.
    wa_en = 1'b1; wa_addr = 5'd5; wa_data = 64'hAB;
    tick();
    wa_en = 1'b0;
    set_rd(0, 5'd5);
    #1;
    check("pre_clear_e5", rd(0), 64'hAB);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    wa_en = 1'b1; wa_addr = 5'd5; wa_data = 64'h77;
    #1;
    check("clear_busy", 64'(busy), 64'd1);
    check("clear_rd_zero", rd(0), 64'd0);
    count_busy("clear_busy_cycles", DEPTH);
    wa_en = 1'b0;
    #1;
    check("post_clear_e5", rd(0), 64'd0);
    set_rd(1, 5'd3);
    #1;
    check("post_clear_e3", rd(1), 64'd0);

    // A second clear request mid-sweep restarts from zero.
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (5) tick();
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    check("restart_cnt", 64'(u_dut.u_ctrl.cnt_q), 64'd0);
    count_busy("restart_busy_cycles", DEPTH);

    // Reset asserted mid-sweep.
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (10) tick();
    rst = 1'b1;
    #1;
    check("midsweep_rst_busy", 64'(busy), 64'd1);
    check("midsweep_rst_cnt", 64'(u_dut.u_ctrl.cnt_q), 64'd0);
    check("midsweep_rst_rd0", rd(0), 64'd0);
    tick();
    tick();
    check("midsweep_rst_hold", 64'(busy), 64'd1);
    rst = 1'b0;
    count_busy("midsweep_busy_cycles", DEPTH);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
